// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and the
// default operand width.
package seq_divider_pkg;

  localparam int DEFAULT_OPERAND_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift-subtract iteration on magnitudes.
// The incoming partial remainder is already shifted (it carries the current
// dividend bit in its LSB), so it can reach W+1 bits. If it is at least the
// divisor, the divisor is subtracted and the quotient bit is 1; otherwise it is
// kept. The kept value is always below the divisor, so W bits suffice for it.
// That value is shifted left again with the next dividend bit appended.
module seq_divider_div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   rem_i,
  input  logic         dvd_bit_i,
  input  logic [W-1:0] dvs_i,
  output logic [W:0]   rem_o,
  output logic         q_bit_o
);

  logic         ge_s;
  logic [W-1:0] kept_s;

  // Compare, conditionally subtract, then shift in the next dividend bit.
  always_comb begin
    ge_s = (rem_i >= {1'b0, dvs_i});
    if (ge_s) begin
      kept_s = W'(rem_i - {1'b0, dvs_i});
    end else begin
      kept_s = rem_i[W-1:0];
    end
    rem_o   = {kept_s, dvd_bit_i};
    q_bit_o = ge_s;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential radix-2 restoring divider supporting signed and unsigned
// division and remainder. It handles one request at a time and uses a
// valid/ready handshake on both request and response. A normal division takes
// OPERAND_WIDTH iterations. Divide-by-zero and signed overflow skip the
// iterations and go straight to the response.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int OPERAND_WIDTH = DEFAULT_OPERAND_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OPERAND_WIDTH-1:0] op1,
  input  logic [OPERAND_WIDTH-1:0] op2,
  input  logic                     is_signed,
  input  logic                     want_rem,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OPERAND_WIDTH-1:0] result,
  output logic                     busy
);

  localparam int W  = OPERAND_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
  localparam logic [W-1:0]  ZERO      = {W{1'b0}};
  localparam logic [W-1:0]  ALL_ONES  = {W{1'b1}};
  localparam logic [W-1:0]  MOST_NEG  = {1'b1, {(W-1){1'b0}}};

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [W:0]    rem_q;      // shifted partial remainder
  logic [W-1:0]  quo_q;      // remaining dividend bits out the top, quotient bits in the bottom
  logic [W-1:0]  dvs_q;      // divisor magnitude
  logic          neg_quo_q;  // negate the quotient at the end
  logic          neg_rem_q;  // negate the remainder at the end
  logic          want_rem_q;
  logic [W-1:0]  result_q;

  // Request decode: operand signs, magnitudes and special cases
  logic          accept_s;
  logic          div_zero_s;
  logic          sovf_s;
  logic          special_s;
  logic          a_neg_s;
  logic          b_neg_s;
  logic [W-1:0]  op1_mag_s;
  logic [W-1:0]  op2_mag_s;
  logic [W-1:0]  special_res_s;

  // Iteration datapath
  logic [W:0]    step_rem_s;
  logic          step_q_s;
  logic [W-1:0]  final_quo_s;
  logic [W-1:0]  final_rem_s;
  logic [W-1:0]  fixed_res_s;

  assign accept_s   = req_valid && (state_q == ST_IDLE);
  assign div_zero_s = (op2 == ZERO);
  assign sovf_s     = is_signed && (op1 == MOST_NEG) && (op2 == ALL_ONES);
  assign special_s  = div_zero_s || sovf_s;
  assign a_neg_s    = is_signed && op1[W-1];
  assign b_neg_s    = is_signed && op2[W-1];
  // The magnitude of the most negative value wraps to itself. As an unsigned
  // number that is the correct magnitude.
  assign op1_mag_s  = a_neg_s ? (ZERO - op1) : op1;
  assign op2_mag_s  = b_neg_s ? (ZERO - op2) : op2;

  // Divide by zero: quotient is all ones and remainder is the dividend.
  // Signed overflow: quotient is the dividend and remainder is zero.
  assign special_res_s = want_rem ? (div_zero_s ? op1 : ZERO)
                                  : (div_zero_s ? ALL_ONES : op1);

  seq_divider_div_step #(.W(W)) u_div_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[W-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem_s),
    .q_bit_o   (step_q_s)
  );

  // On the last step the shifted-in LSB is padding, so the true remainder is
  // the upper W bits.
  assign final_quo_s = {quo_q[W-2:0], step_q_s};
  assign final_rem_s = step_rem_s[W:1];
  assign fixed_res_s = want_rem_q ? (neg_rem_q ? (ZERO - final_rem_s) : final_rem_s)
                                  : (neg_quo_q ? (ZERO - final_quo_s) : final_quo_s);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; flush overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = special_s ? ST_DONE : ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (cnt_q == LAST_STEP) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // FSM outputs decoded from the state register
  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_CALC: busy      = 1'b1;
      ST_DONE: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
      end
      default: begin
        req_ready = 1'b0;
        busy      = 1'b0;
        rsp_valid = 1'b0;
      end
    endcase
  end

  // Datapath: capture operands on accept, iterate in CALC, latch the result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= {CW{1'b0}};
      rem_q      <= {(W+1){1'b0}};
      quo_q      <= ZERO;
      dvs_q      <= ZERO;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      want_rem_q <= 1'b0;
      result_q   <= ZERO;
    end else if (!flush) begin
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            cnt_q      <= {CW{1'b0}};
            rem_q      <= {ZERO, op1_mag_s[W-1]};
            quo_q      <= {op1_mag_s[W-2:0], 1'b0};
            dvs_q      <= op2_mag_s;
            neg_quo_q  <= a_neg_s ^ b_neg_s;
            neg_rem_q  <= a_neg_s;
            want_rem_q <= want_rem;
            if (special_s) begin
              result_q <= special_res_s;
            end
          end
        end
        ST_CALC: begin
          rem_q <= step_rem_s;
          quo_q <= final_quo_s;
          if (cnt_q == LAST_STEP) begin
            cnt_q    <= {CW{1'b0}};
            result_q <= fixed_res_s;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          cnt_q <= cnt_q;
        end
      endcase
    end
  end

  assign result = result_q;

endmodule
